// File: rtl/apu_pkg.sv
// Shared APU constants and types for the frame sequencer.
//   STEP*          : cycle-counter values at which frame steps fire
//   WRAP4          : last count of a 4-step frame (next count is 0)
//   IRQ_FIRST      : first count of the 4-step IRQ window (window ends at WRAP4)
//   RESET_DELAY    : cpu_ce count between a $4017 write and the forced counter reset
//   seq_mode_e     : sequencer mode, encoded as $4017 bit 7
package apu_pkg;

  localparam int unsigned STEP1       = 7457;
  localparam int unsigned STEP2       = 14913;
  localparam int unsigned STEP3       = 22371;
  localparam int unsigned STEP4_4     = 29829;
  localparam int unsigned WRAP4       = 29830;
  localparam int unsigned STEP4_5     = 37281;
  localparam int unsigned IRQ_FIRST   = STEP4_4 - 1;

  localparam int unsigned RESET_DELAY = 3;
  localparam int unsigned RDLY_W      = 2;

  typedef enum logic {
    SEQ_4STEP = 1'b0,
    SEQ_5STEP = 1'b1
  } seq_mode_e;

endpackage

// File: rtl/frame_sequencer_if.sv
// CPU-side bus and tick outputs of the APU frame sequencer.
//   cpu_ce    : one-cycle enable per CPU cycle
//   wr_4017   : $4017 write strobe, wdata[7] = mode, wdata[6] = IRQ inhibit
//   rd_4015   : $4015 read strobe (clears the frame IRQ flag)
//   qframe    : quarter-frame tick, one clk wide
//   hframe    : half-frame tick, one clk wide
//   frame_irq : frame IRQ flag, level
//   mode      : current sequencer mode
// master drives the bus and receives ticks; slave is the sequencer.
interface frame_sequencer_if;

  logic       cpu_ce;
  logic       wr_4017;
  logic [7:0] wdata;
  logic       rd_4015;
  logic       qframe;
  logic       hframe;
  logic       frame_irq;
  logic       mode;

  modport master (
    output cpu_ce, wr_4017, wdata, rd_4015,
    input  qframe, hframe, frame_irq, mode
  );

  modport slave (
    input  cpu_ce, wr_4017, wdata, rd_4015,
    output qframe, hframe, frame_irq, mode
  );

endinterface

// File: rtl/frame_step_decode.sv
// Combinational step decoder: maps the cycle count and mode onto the frame events.
//   cnt  : current cycle count
//   mode : sequencer mode
//   q    : quarter-frame step at this count
//   h    : half-frame step at this count
//   irq  : count lies in the 4-step IRQ window
//   wrap : count is the last step of the frame; next count is 0
module frame_step_decode
  import apu_pkg::*;
#(
  parameter int unsigned STEP_W = 16
) (
  input  logic [STEP_W-1:0] cnt,
  input  seq_mode_e         mode,
  output logic              q,
  output logic              h,
  output logic              irq,
  output logic              wrap
);

  localparam logic [STEP_W-1:0] S1   = STEP_W'(STEP1);
  localparam logic [STEP_W-1:0] S2   = STEP_W'(STEP2);
  localparam logic [STEP_W-1:0] S3   = STEP_W'(STEP3);
  localparam logic [STEP_W-1:0] S44  = STEP_W'(STEP4_4);
  localparam logic [STEP_W-1:0] W4   = STEP_W'(WRAP4);
  localparam logic [STEP_W-1:0] S45  = STEP_W'(STEP4_5);
  localparam logic [STEP_W-1:0] IRQ0 = STEP_W'(IRQ_FIRST);

  always_comb begin
    q    = 1'b0;
    h    = 1'b0;
    irq  = 1'b0;
    wrap = 1'b0;
    if (cnt == S1 || cnt == S3) begin
      q = 1'b1;
    end
    if (cnt == S2) begin
      q = 1'b1;
      h = 1'b1;
    end
    if (mode == SEQ_4STEP) begin
      if (cnt == S44) begin
        q = 1'b1;
        h = 1'b1;
      end
      irq  = (cnt >= IRQ0) && (cnt <= W4);
      // >= so a count left high by a mode switch still wraps
      wrap = (cnt >= W4);
    end else begin
      if (cnt == S45) begin
        q = 1'b1;
        h = 1'b1;
      end
      wrap = (cnt >= S45);
    end
  end

endmodule

// File: rtl/frame_sequencer.sv
// NES APU frame sequencer: counts CPU cycles and emits quarter/half-frame ticks,
// owns the $4017 mode/inhibit register and the frame IRQ flag.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : frame_sequencer_if.slave (cpu_ce, wr_4017, wdata, rd_4015 in;
//           qframe, hframe, frame_irq, mode out)
// Build option FRAME_IRQ_EN: when defined, the inhibit bit, IRQ flag and $4015 clear
// path are built; otherwise frame_irq is tied to 0 and wdata[6]/rd_4015 are ignored.
module frame_sequencer
  import apu_pkg::*;
#(
  parameter int unsigned STEP_W = 16
) (
  input logic              clk,
  input logic              rst_n,
  frame_sequencer_if.slave bus
);

  logic [STEP_W-1:0] cnt;
  logic [RDLY_W-1:0] rdly;    // 0 = RUN, non-zero = PEND (counting continues)
  seq_mode_e         mode;
  logic              qframe;
  logic              hframe;
  logic              dec_q;
  logic              dec_h;
  logic              dec_irq;
  logic              dec_wrap;
  logic              reset_lands;

  frame_step_decode #(
    .STEP_W (STEP_W)
  ) u_decode (
    .cnt  (cnt),
    .mode (mode),
    .q    (dec_q),
    .h    (dec_h),
    .irq  (dec_irq),
    .wrap (dec_wrap)
  );

  // The delayed reset takes effect on the cpu_ce that moves rdly from 1 to 0.
  assign reset_lands = bus.cpu_ce && (rdly == RDLY_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      rdly   <= '0;
      mode   <= SEQ_4STEP;
      qframe <= 1'b0;
      hframe <= 1'b0;
    end else begin
      qframe <= 1'b0;
      hframe <= 1'b0;
      if (bus.cpu_ce) begin
        cnt <= (reset_lands || dec_wrap) ? '0 : cnt + 1'b1;
        if (rdly != '0) begin
          rdly <= rdly - 1'b1;
        end
        // A scheduled step coinciding with the forced reset still ticks.
        qframe <= dec_q || (reset_lands && mode == SEQ_5STEP);
        hframe <= dec_h || (reset_lands && mode == SEQ_5STEP);
      end
      // A write (also one made during PEND) restarts the delay with the new mode.
      if (bus.wr_4017) begin
        mode <= seq_mode_e'(bus.wdata[7]);
        rdly <= RDLY_W'(RESET_DELAY);
      end
    end
  end

  assign bus.qframe = qframe;
  assign bus.hframe = hframe;
  assign bus.mode   = mode;

`ifdef FRAME_IRQ_EN
  logic inhibit;
  logic irq_flag;
  logic unused_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inhibit  <= 1'b0;
      irq_flag <= 1'b0;
    end else begin
      // Set beats the $4015 read clear; an inhibiting write beats both.
      if (bus.cpu_ce && dec_irq && !inhibit) begin
        irq_flag <= 1'b1;
      end else if (bus.rd_4015) begin
        irq_flag <= 1'b0;
      end
      if (bus.wr_4017) begin
        inhibit <= bus.wdata[6];
        if (bus.wdata[6]) begin
          irq_flag <= 1'b0;
        end
      end
    end
  end

  assign bus.frame_irq = irq_flag;
  assign unused_wdata  = ^bus.wdata[5:0];
`else
  logic unused_irq;

  assign bus.frame_irq = 1'b0;
  assign unused_irq    = ^{bus.wdata[6:0], bus.rd_4015, dec_irq};
`endif

endmodule

// File: tb/tb_frame_sequencer.sv
// Self-checking bench for frame_sequencer. Expected tick/IRQ events (tagged with the
// cpu_ce count after which they must appear) are queued by the stimulus; a monitor
// compares every observed event against the queue.
module tb_frame_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  frame_sequencer_if bus ();

  frame_sequencer #(
    .STEP_W (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

`ifdef FRAME_IRQ_EN
  localparam logic IRQ_EN = 1'b1;
`else
  localparam logic IRQ_EN = 1'b0;
`endif

  typedef struct packed {
    int unsigned ce;
    logic        q;
    logic        h;
    logic        irq;
  } ev_t;

  ev_t         exp_q[$];
  int unsigned ce_n     = 0;
  int          checks   = 0;
  int          failures = 0;
  logic        irq_prev = 1'b0;

  always @(posedge clk) begin
    if (bus.cpu_ce) ce_n <= ce_n + 1;
  end

  // Monitor: any tick or IRQ level change is an event that must match the queue head.
  always @(negedge clk) begin : monitor
    ev_t got;
    ev_t want;
    if (bus.qframe || bus.hframe || (bus.frame_irq !== irq_prev)) begin
      got.ce  = ce_n;
      got.q   = bus.qframe;
      got.h   = bus.hframe;
      got.irq = bus.frame_irq;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL event_unexpected got ce=%0d q=%0d h=%0d irq=%0d required=no event",
                 got.ce, got.q, got.h, got.irq);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          failures++;
          $display("FAIL event got ce=%0d q=%0d h=%0d irq=%0d required ce=%0d q=%0d h=%0d irq=%0d",
                   got.ce, got.q, got.h, got.irq, want.ce, want.q, want.h, want.irq);
        end
      end
    end
    irq_prev <= bus.frame_irq;
  end

  function automatic void push_ev(input int unsigned ce, input logic q, input logic h,
                                  input logic irq);
    ev_t e;
    e.ce  = ce;
    e.q   = q;
    e.h   = h;
    e.irq = irq;
    exp_q.push_back(e);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0d required=%0d", name, got, want);
    end
  endtask

  task automatic drain(input string name);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s missing_events=%0d required=0 next_ce=%0d", name, exp_q.size(),
               exp_q[0].ce);
      exp_q.delete();
    end
  endtask

  task automatic tick(input int n);
    bus.cpu_ce = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    bus.cpu_ce = 1'b0;
  endtask

  task automatic wr(input logic [7:0] d);
    bus.wdata   = d;
    bus.wr_4017 = 1'b1;
    @(posedge clk);
    #1;
    bus.wr_4017 = 1'b0;
  endtask

  task automatic rd();
    bus.rd_4015 = 1'b1;
    @(posedge clk);
    #1;
    bus.rd_4015 = 1'b0;
  endtask

  initial begin : stim
    int unsigned b;
    bus.cpu_ce  = 1'b0;
    bus.wr_4017 = 1'b0;
    bus.wdata   = 8'h00;
    bus.rd_4015 = 1'b0;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_qframe", bus.qframe, 0);
    check("reset_hframe", bus.hframe, 0);
    check("reset_irq", bus.frame_irq, 0);
    check("reset_mode", bus.mode, 0);
    check("reset_cnt", dut.cnt, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Count to 20000, enter PEND with a 5-step write, then reset mid-PEND
    b = ce_n;
    push_ev(b + 7458, 1'b1, 1'b0, 1'b0);
    push_ev(b + 14914, 1'b1, 1'b1, 1'b0);
    tick(20000);
    wr(8'h80);
    check("pend_mode", bus.mode, 1);
    tick(1);
    check("pend_rdly", dut.rdly, 2);
    drain("run_to_20000");
    rst_n = 1'b0;
    #1;
    check("rst_pend_qframe", bus.qframe, 0);
    check("rst_pend_hframe", bus.hframe, 0);
    check("rst_pend_irq", bus.frame_irq, 0);
    check("rst_pend_mode", bus.mode, 0);
    check("rst_pend_rdly", dut.rdly, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Full 4-step frame from release; no delayed 5-step tick may appear
    b = ce_n;
    push_ev(b + 7458, 1'b1, 1'b0, 1'b0);
    push_ev(b + 14914, 1'b1, 1'b1, 1'b0);
    push_ev(b + 22372, 1'b1, 1'b0, 1'b0);
    if (IRQ_EN) push_ev(b + 29829, 1'b0, 1'b0, 1'b1);
    push_ev(b + 29830, 1'b1, 1'b1, IRQ_EN);
    tick(29829);
    check("irq_set_29828", bus.frame_irq, IRQ_EN);
    // rd_4015 on count 29829 with cpu_ce: the set wins
    bus.rd_4015 = 1'b1;
    tick(1);
    bus.rd_4015 = 1'b0;
    check("irq_set_beats_rd", bus.frame_irq, IRQ_EN);
    if (IRQ_EN) push_ev(ce_n, 1'b0, 1'b0, 1'b0);
    rd();
    check("irq_rd_clear", bus.frame_irq, 0);
    // Count 29830 sets the flag again, then the counter wraps
    if (IRQ_EN) push_ev(ce_n + 1, 1'b0, 1'b0, 1'b1);
    tick(1);
    check("irq_set_29830", bus.frame_irq, IRQ_EN);
    check("wrap_4step", dut.cnt, 0);
    // Inhibiting write clears the flag at once
    if (IRQ_EN) push_ev(ce_n, 1'b0, 1'b0, 1'b0);
    wr(8'h40);
    check("inhibit_clear", bus.frame_irq, 0);
    check("inhibit_mode", bus.mode, 0);
    drain("frame_4step");

    // Full 4-step frame with inhibit set: ticks only, flag stays 0
    b = ce_n + 3;
    push_ev(b + 7458, 1'b1, 1'b0, 1'b0);
    push_ev(b + 14914, 1'b1, 1'b1, 1'b0);
    push_ev(b + 22372, 1'b1, 1'b0, 1'b0);
    push_ev(b + 29830, 1'b1, 1'b1, 1'b0);
    tick(3 + 29831);
    check("wrap_inhibit_frame", dut.cnt, 0);
    drain("frame_inhibit");

    // 5-step: immediate q+h when the delayed reset lands, then the 5-step schedule
    wr(8'h80);
    check("mode_5step", bus.mode, 1);
    b = ce_n + 3;
    push_ev(b, 1'b1, 1'b1, 1'b0);
    push_ev(b + 7458, 1'b1, 1'b0, 1'b0);
    push_ev(b + 14914, 1'b1, 1'b1, 1'b0);
    push_ev(b + 22372, 1'b1, 1'b0, 1'b0);
    push_ev(b + 37282, 1'b1, 1'b1, 1'b0);
    tick(3 + 37282);
    check("wrap_5step", dut.cnt, 0);
    check("irq_5step", bus.frame_irq, 0);
    drain("frame_5step");

    // Second write during PEND restarts the delay
    tick(1000);
    wr(8'h80);
    tick(1);
    wr(8'h80);
    push_ev(ce_n + 3, 1'b1, 1'b1, 1'b0);
    tick(2);
    check("rewrite_still_pend", dut.cnt, 1003);
    tick(1);
    check("rewrite_landed", dut.cnt, 0);
    tick(5);
    drain("double_write");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
